// File: rtl/regfile_onehot_sb.sv
// 32 x N register file (x0 = 0), one-hot write port, two write-through read ports, busy scoreboard.
// Reads/stall are combinational (0 cycles); writes/busy land at the edge; stall holds the issue stage.
module regfile_onehot_sb #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reg_write,
  input  logic [31:0]   wr_sel,
  input  logic [N-1:0]  wr_data,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic [N-1:0]  rd_data1,
  output logic [N-1:0]  rd_data2,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  input  logic          issue_has_rd,
  output logic          stall,
  output logic [31:0]   busy,
  output logic          wr_err
);

  logic [N-1:0] regs [0:31];
  logic [31:0]  busy_q;
  logic [31:0]  busy_next;
  logic [31:0]  wr_en;
  logic [31:0]  pending;
  logic [31:0]  set_vec;
  logic         sel_onehot;
  logic         legal_wr;
  logic         bad_wr;
  logic         accept;

  assign sel_onehot = (wr_sel != 32'd0) && ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
  assign legal_wr   = reg_write && sel_onehot;
  assign bad_wr     = reg_write && !sel_onehot;
  assign wr_en      = legal_wr ? wr_sel : 32'd0;

  // A register whose writeback lands this cycle is already safe to read.
  assign pending = busy_q & ~wr_en;

  assign stall  = issue_valid &&
                  (pending[rs1] || pending[rs2] || (issue_has_rd && pending[issue_rd]));
  assign accept = issue_valid && !stall;

  always_comb begin
    set_vec = 32'd0;
    if (accept && issue_has_rd && (issue_rd != 5'd0))
      set_vec = 32'd1 << issue_rd;
  end

  // Set after clear: a newly issued owner wins over the old writeback.
  assign busy_next = ((busy_q & ~wr_en) | set_vec) & 32'hFFFF_FFFE;
  assign busy      = busy_q;

  always_comb begin
    rd_data1 = regs[rs1];
    if (rs1 == 5'd0)
      rd_data1 = '0;
    else if (wr_en[rs1])
      rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = regs[rs2];
    if (rs2 == 5'd0)
      rd_data2 = '0;
    else if (wr_en[rs2])
      rd_data2 = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++)
        regs[k] <= '0;
    end else begin
      for (int k = 1; k < 32; k++)
        if (wr_en[k])
          regs[k] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
      wr_err <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (bad_wr)
        wr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_onehot_sb.sv
// Bench for regfile_onehot_sb: directed plan steps then random traffic, all outputs
// compared each cycle against an array/popcount model of the register file and scoreboard.
module tb_regfile_onehot_sb;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_write;
  logic [31:0]   wr_sel;
  logic [N-1:0]  wr_data;
  logic [4:0]    rs1, rs2;
  logic [N-1:0]  rd_data1, rd_data2;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_has_rd;
  logic          stall;
  logic [31:0]   busy;
  logic          wr_err;

  regfile_onehot_sb #(.N(N)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .wr_sel(wr_sel), .wr_data(wr_data),
    .rs1(rs1), .rs2(rs2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
    .stall(stall), .busy(busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [N-1:0] m_reg [32];
  bit           m_busy [32];
  bit           m_err;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal();
    return reg_write && ($countones(wr_sel) == 1);
  endfunction

  function automatic int m_target();
    int t = -1;
    for (int i = 0; i < 32; i++)
      if (wr_sel[i]) t = i;
    return t;
  endfunction

  function automatic logic [N-1:0] m_read(input int r);
    if (r == 0) return '0;
    if (m_legal() && m_target() == r) return wr_data;
    return m_reg[r];
  endfunction

  function automatic bit m_pending(input int r);
    return m_busy[r] && !(m_legal() && m_target() == r);
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_pending(rs1) || m_pending(rs2) ||
                           (issue_has_rd && m_pending(issue_rd)));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Compare all outputs against the model, clock once, advance the model.
  task automatic step();
    bit st;
    #1;
    st = m_stall();
    check("rd_data1", rd_data1, m_read(rs1));
    check("rd_data2", rd_data2, m_read(rs2));
    check("stall", {31'd0, stall}, {31'd0, st});
    check("busy", busy, m_busy_vec());
    check("wr_err", {31'd0, wr_err}, {31'd0, m_err});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
      m_err = 0;
    end else begin
      if (m_legal() && m_target() != 0) begin
        m_reg[m_target()] = wr_data;
        m_busy[m_target()] = 0;
      end
      if (reg_write && !m_legal()) m_err = 1;
      if (issue_valid && !st && issue_has_rd && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; reg_write = 0; wr_sel = '0; wr_data = '0;
    issue_valid = 0; issue_rd = '0; issue_has_rd = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_reg[i] = 'x; m_busy[i] = 0; end
    m_err = 0;
    idle(); rs1 = '0; rs2 = '0;
    @(posedge clk); #1;

    // Reset, then read every register
    rst = 1;
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    m_err = 0;
    #1; idle();
    check("reset_busy", busy, 32'd0);
    check("reset_err", {31'd0, wr_err}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      step();
    end

    // Write and same-cycle bypass
    reg_write = 1; wr_sel = 32'h0000_0020; wr_data = 32'hDEAD_BEEF; rs1 = 5'd5; rs2 = 5'd0;
    #1; check("bypass_x5", rd_data1, 32'hDEAD_BEEF);
    step();
    idle();
    #1; check("stored_x5", rd_data1, 32'hDEAD_BEEF);
    step();

    // Write to x0 is discarded
    reg_write = 1; wr_sel = 32'h0000_0001; wr_data = 32'h1234_5678; rs1 = 5'd0; rs2 = 5'd0;
    step();
    idle();
    #1; check("x0_zero", rd_data1, 32'd0);
    step();

    // RAW on x7
    issue_valid = 1; issue_rd = 5'd7; issue_has_rd = 1; rs1 = 5'd0; rs2 = 5'd0;
    step();
    idle();
    check("busy7_set", {31'd0, busy[7]}, 32'd1);
    issue_valid = 1; rs2 = 5'd7;
    #1; check("raw_stall", {31'd0, stall}, 32'd1);
    step();
    reg_write = 1; wr_sel = 32'h0000_0080; wr_data = 32'h0000_A5A5;
    issue_valid = 1; rs2 = 5'd7;
    #1;
    check("raw_release", {31'd0, stall}, 32'd0);
    check("raw_bypass", rd_data2, 32'h0000_A5A5);
    step();
    idle();

    // Set/clear collision on x3
    issue_valid = 1; issue_rd = 5'd3; issue_has_rd = 1; rs1 = 5'd0; rs2 = 5'd0;
    step();
    reg_write = 1; wr_sel = 32'h0000_0008; wr_data = 32'h3333_3333;
    issue_valid = 1; issue_rd = 5'd3; issue_has_rd = 1;
    step();
    idle();
    check("collide_busy3", {31'd0, busy[3]}, 32'd1);

    // Malformed selects
    reg_write = 1; wr_sel = 32'h0000_0006; wr_data = 32'hFFFF_FFFF; rs1 = 5'd1; rs2 = 5'd2;
    step();
    idle(); rs1 = 5'd1; rs2 = 5'd2;
    #1;
    check("bad_x1", rd_data1, 32'd0);
    check("bad_x2", rd_data2, 32'd0);
    check("bad_err", {31'd0, wr_err}, 32'd1);
    step();
    reg_write = 1; wr_sel = 32'd0; wr_data = 32'h5555_5555; rs1 = 5'd5;
    step();
    idle(); rs1 = 5'd5;
    step();
    check("err_sticky", {31'd0, wr_err}, 32'd1);
    check("zero_sel_x5", rd_data1, 32'hDEAD_BEEF);

    // WAW on x9, with reset in the stalled cycle
    issue_valid = 1; issue_rd = 5'd9; issue_has_rd = 1; rs1 = 5'd0; rs2 = 5'd0;
    step();
    issue_valid = 1; issue_rd = 5'd9; issue_has_rd = 1; rst = 1;
    #1; check("waw_stall", {31'd0, stall}, 32'd1);
    step();
    idle();
    check("rst_busy", busy, 32'd0);
    check("rst_err", {31'd0, wr_err}, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int pick;
      rst = ($urandom_range(0, 79) == 0);
      reg_write = $urandom_range(0, 1);
      pick = $urandom_range(0, 9);
      if (pick == 0) wr_sel = 32'd0;
      else if (pick == 1) wr_sel = $urandom;
      else wr_sel = 32'd1 << $urandom_range(0, 31);
      wr_data = $urandom;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      issue_valid = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 31));
      issue_has_rd = $urandom_range(0, 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_onehot_sb.md
# regfile_onehot_sb

Architectural register file for the RISC-V core: 32 registers × N bits, with two combinational read ports and one write port. The write port is selected by the one-hot vector that the 5-to-32 write-address decoder produces. A per-register busy scoreboard tracks in-flight destination writes, and a combinational `stall` tells the issue stage when a source or destination register is not yet safe to use. The block sits between the decode/issue stage and writeback; the decoder output feeds `wr_sel` directly.

## Interface
- `N`, default 32: register data width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `reg_write`  in  1  writeback strobe.
- `wr_sel`  in  32  one-hot write-register select, from the decoder.
- `wr_data`  in  N  writeback data.
- `rs1`, `rs2`  in  5 each  read addresses.
- `rd_data1`, `rd_data2`  out  N each  read data.
- `issue_valid`  in  1  the issue stage presents an instruction.
- `issue_rd`  in  5  destination of the issuing instruction.
- `issue_has_rd`  in  1  the issuing instruction writes `issue_rd`.
- `stall`  out  1  issue must hold.
- `busy`  out  32  scoreboard vector. Bit 0 is always 0.
- `wr_err`  out  1  registered flag: a malformed `wr_sel` was seen.

## Operation
**Storage: `regs[1..31]`**
- Reads at x0 always return 0. Writes to x0 are discarded.
- A write is legal when `reg_write` = 1 and `wr_sel` has exactly one bit set.
- A legal write updates `regs[k]`, where `wr_sel[k]` = 1 and k ≠ 0.
- When `reg_write` = 1 and `wr_sel` has zero bits or more than one bit set:
  - No register is written.
  - `wr_err` = 1 on the next cycle.
  - The busy vector is unchanged.

**Read bypass (write-through)**
- If a legal write targets `rsX` ≠ 0 in the same cycle, `rd_dataX` = `wr_data`.
- Otherwise `rd_dataX` = `regs[rsX]`.

**Scoreboard**
- Hazard when `issue_valid` = 1 and any of:
  - `busy[rs1]` is set and not cleared by a legal write to rs1 this cycle;
  - the same condition holds for rs2;
  - `issue_has_rd` = 1 and `busy[issue_rd]` is set and not cleared this cycle (WAW).
- `stall` = hazard. It is combinational and depends only on current inputs and state.
- **Accept:** `issue_valid` = 1 and `stall` = 0.
  - If `issue_has_rd` = 1 and `issue_rd` ≠ 0, set `busy[issue_rd]` at the edge.
- **Clear:** a legal write clears `busy[k]` at the edge.
- **Simultaneous set and clear of the same k:** set wins, because the new instruction owns the register.
- x0 is never marked busy, and never causes a stall.
- `wr_err` is sticky until `rst`.

## Timing
- **Reset values:**
  - `regs` = 0 and `busy` = 0.
  - `wr_err` = 0.
  - `stall` = 0 while `issue_valid` = 0.
  - `rd_data1` and `rd_data2` = 0 on the cycle after reset, absent a write.
- **Write latency:** data is visible in `regs` on the cycle after the edge, and visible through the bypass in the same cycle.
- **Busy timing:**
  - `busy` bits update at the edge after accept or writeback.
  - `stall` reflects the new `busy` values one cycle later.
- **Reset mid-operation:** `rst` overrides every same-cycle write and issue. All state returns to its reset value at that edge.
- **Writeback without a busy bit set:** the write proceeds normally. This is not an error.
- No other multi-cycle paths; every output is valid in the cycle it is sampled.

## Test plan
- **Reset:** after `rst`, read all 32 registers → all 0; `busy` = 0; `wr_err` = 0.
- **Write and bypass:**
  - Write `0xDEADBEEF` with `wr_sel` = `0x00000020` → `rd_data1` (`rs1` = 5) = `0xDEADBEEF` in the same cycle and the next.
  - Write to `wr_sel` = `0x00000001` → x0 still reads 0.
- **RAW stall:**
  - Accept an issue with `issue_rd` = 7 → `busy[7]` = 1 next cycle.
  - An issue with `rs2` = 7 → `stall` = 1.
  - On the writeback cycle to x7 → `stall` = 0, and `rd_data2` shows `wr_data`.
- **Set/clear collision:** writeback to x3 and an accepted issue with `issue_rd` = 3 in the same cycle → `busy[3]` = 1 afterwards.
- **Malformed select:**
  - `reg_write` = 1 with `wr_sel` = `0x00000006` → no register changes, and `wr_err` = 1 next cycle and stays 1.
  - With `wr_sel` = 0 → same result.
- **WAW and reset:**
  - An issue with `issue_rd` = 9 while `busy[9]` = 1 → `stall` = 1.
  - Assert `rst` that same cycle → `busy` = 0 next cycle; the issue is not recorded.
